pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 62 ++++++
 tb/tb_pipe_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard detection and stall/flush control for a five-stage pipeline.
module pipe_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_is_load,
   input  logic        ex_md_valid,
   input  logic        md_done,
   input  logic        branch_taken,
   input  logic        imem_ready,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   output logic        stall_pc,
   output logic        stall_if,
   output logic        stall_id,
   output logic        stall_ex,
   output logic        stall_mem,
   output logic        flush_id,
   output logic        flush_ex,
   output logic        flush_mem,
   output logic        flush_wb,
   output logic [1:0]  state,
   output logic [15:0] stall_cnt
);
   typedef enum logic [1:0] {RUN, LU_STALL, MD_WAIT, DMEM_WAIT} state_t;
   state_t cur, nxt;
   logic dm, md, lu, ifm, live;
   logic [8:0] act;
   // act packs {stall_pc, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb}
   always_comb begin
      dm   = dmem_req & ~dmem_ready;
      md   = ex_md_valid & ~md_done;
      lu   = ex_is_load & (ex_rd != 5'd0) &
             ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
      ifm  = ~imem_ready;
      live = cur != LU_STALL;
      act  = !rst                ? 9'b00000_1111 :
             dm                  ? 9'b11111_0001 :
             md                  ? 9'b11110_0010 :
             live & branch_taken ? 9'b00000_1100 :
             live & lu           ? 9'b11000_0100 :
             live & ifm          ? 9'b10000_1000 : 9'b0;
      nxt  = dm ? DMEM_WAIT : md ? MD_WAIT :
             (live & ~branch_taken & lu) ? LU_STALL : RUN;
   end
   assign {stall_pc, stall_if, stall_id, stall_ex, stall_mem,
           flush_id, flush_ex, flush_mem, flush_wb} = act;
   assign state = cur;
   always_ff @(posedge clk) begin
      if (!rst) begin
         cur       <= RUN;
         stall_cnt <= 16'd0;
      end else begin
         cur       <= nxt;
         stall_cnt <= stall_cnt + 16'(stall_pc);
      end
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios checked against a priority-table model every cycle.
module tb_pipe_ctrl;
   logic        clk = 0, rst = 0;
   logic [4:0]  id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
   logic        id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0, ex_md_valid = 0, md_done = 0;
   logic        branch_taken = 0, imem_ready = 1, dmem_req = 0, dmem_ready = 0;
   logic        stall_pc, stall_if, stall_id, stall_ex, stall_mem;
   logic        flush_id, flush_ex, flush_mem, flush_wb;
   logic [1:0]  state;
   logic [15:0] stall_cnt;
   int tests = 0, fails = 0;
   bit armed = 0;
   int m_state = 0, m_cnt = 0;

   pipe_ctrl dut (.clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_is_load(ex_is_load), .ex_md_valid(ex_md_valid), .md_done(md_done),
      .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_req(dmem_req),
      .dmem_ready(dmem_ready), .stall_pc(stall_pc), .stall_if(stall_if),
      .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
      .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
      .flush_wb(flush_wb), .state(state), .stall_cnt(stall_cnt));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", n, a, e, $time);
      end
   endtask

   // Model: pick the winning condition from the priority list, then look up its response.
   always @(negedge clk) begin
      string win;
      logic [8:0] exp_o;
      int ns;
      bit c_dm, c_md, c_lu, c_if, scan;
      c_dm = dmem_req && !dmem_ready;
      c_md = ex_md_valid && !md_done;
      c_lu = ex_is_load && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      c_if = !imem_ready;
      scan = m_state != 1;
      if (!rst) win = "reset";
      else if (c_dm) win = "dm";
      else if (c_md) win = "md";
      else if (scan && branch_taken) win = "br";
      else if (scan && c_lu) win = "lu";
      else if (scan && c_if) win = "if";
      else win = "none";
      case (win)
         "reset": begin exp_o = 9'b00000_1111; ns = 0; end
         "dm":    begin exp_o = 9'b11111_0001; ns = 3; end
         "md":    begin exp_o = 9'b11110_0010; ns = 2; end
         "br":    begin exp_o = 9'b00000_1100; ns = 0; end
         "lu":    begin exp_o = 9'b11000_0100; ns = 1; end
         "if":    begin exp_o = 9'b10000_1000; ns = 0; end
         default: begin exp_o = 9'b0;          ns = 0; end
      endcase
      if (armed) begin
         chk("model_outs", {stall_pc, stall_if, stall_id, stall_ex, stall_mem,
                            flush_id, flush_ex, flush_mem, flush_wb}, exp_o);
         chk("model_state", state, m_state);
         chk("model_cnt", stall_cnt, m_cnt);
      end
      m_state = ns;
      m_cnt = !rst ? 0 : (m_cnt + exp_o[8]) % 65536;
   end

   task automatic at_neg; @(negedge clk); #1; endtask
   task automatic at_pos; @(posedge clk); #1; endtask
   task automatic idle;
      {id_rs1, id_rs2, ex_rd} = 0;
      {id_use_rs1, id_use_rs2, ex_is_load, ex_md_valid, md_done} = 0;
      {branch_taken, dmem_req, dmem_ready} = 0;
      imem_ready = 1;
   endtask
   task automatic do_reset;
      rst = 0; at_pos; armed = 1; rst = 1;
   endtask

   initial begin
      idle;
      at_neg;
      chk("rst_stall_pc", stall_pc, 0);
      chk("rst_flush_all", {flush_id, flush_ex, flush_mem, flush_wb}, 4'hF);
      do_reset;
      chk("rst_state", state, 0);
      chk("rst_cnt", stall_cnt, 0);
      // load-use on rs2
      ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
      at_neg;
      chk("lu_outs", {stall_pc, stall_if, stall_id, flush_ex}, 4'b1101);
      chk("lu_state0", state, 0);
      at_pos;
      chk("lu_state1", state, 1);
      chk("lu_cnt", stall_cnt, 1);
      at_neg;
      chk("lu_suppressed", {stall_pc, flush_ex}, 2'b00);
      idle;
      at_pos;
      chk("lu_back_run", state, 0);
      // x0 never hazards
      ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
      at_neg;
      chk("x0_no_stall", stall_pc, 0);
      at_pos;
      chk("x0_state", state, 0);
      idle;
      // fetch miss
      imem_ready = 0;
      at_neg;
      chk("if_outs", {stall_pc, stall_if, flush_id}, 3'b101);
      at_pos; idle;
      // mul/div wait
      do_reset;
      ex_md_valid = 1;
      for (int i = 0; i < 4; i++) begin
         at_neg;
         chk("md_stall", {stall_pc, stall_if, stall_id, stall_ex, stall_mem, flush_mem}, 6'b111101);
         at_pos;
         chk("md_state", state, 2);
      end
      md_done = 1;
      at_neg;
      chk("md_release", stall_pc, 0);
      at_pos;
      chk("md_done_state", state, 0);
      chk("md_cnt", stall_cnt, 4);
      idle;
      // dm beats branch and load-use
      dmem_req = 1; branch_taken = 1;
      ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
      at_neg;
      chk("pri_dm_outs", {stall_mem, flush_wb, flush_id, flush_ex}, 4'b1100);
      at_pos;
      chk("pri_state3", state, 3);
      dmem_ready = 1;
      at_neg;
      chk("pri_branch", {stall_pc, flush_id, flush_ex}, 3'b011);
      at_pos;
      chk("pri_state0", state, 0);
      idle;
      // counter wrap then reset mid-stall
      do_reset;
      dmem_req = 1;
      repeat (65537) at_pos;
      chk("wrap_cnt", stall_cnt, 1);
      chk("wrap_state", state, 3);
      rst = 0;
      at_neg;
      chk("midrst_stall", {stall_pc, stall_if, stall_id, stall_ex, stall_mem}, 0);
      chk("midrst_flush", {flush_id, flush_ex, flush_mem, flush_wb}, 4'hF);
      at_pos;
      chk("midrst_state", state, 0);
      chk("midrst_cnt", stall_cnt, 0);
      rst = 1; dmem_req = 0;
      at_neg;
      chk("post_rst_no_stall", {stall_pc, stall_ex}, 0);
      at_pos;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
